// File: rtl/exe_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forwarding-select codes
// and the shadow-pipeline slot record.
package exe_ctrl_pkg;

  localparam int DEST_W = 4;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [DEST_W-1:0] dest;
    logic              wb_en;
    logic              mem_r_en;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Combinational tag compare of one ID source register against one shadow slot.
module hazard_match
  import exe_ctrl_pkg::*;
(
  input  slot_t             slot,
  input  logic [DEST_W-1:0] src,
  input  logic              src_used,
  output logic              hit
);

  // Load flag is consumed by the caller from the slot directly.
  logic unused_ld;
  assign unused_ld = slot.mem_r_en;

  assign hit = slot.valid & slot.wb_en & src_used & (slot.dest == src);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage sequencing: shadow EXE/MEM/WB tags, registered forwarding selects,
// load-use stall and branch flush. Forwarding enabled by defining EXE_FWD_EN.
module exe_hazard_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             exe_branch_taken,
  input  logic             mem_freeze,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             hazard_stall,
  output logic             flush
);

  slot_t exe_q, mem_q, wb_q;
  logic  exe_hit1, exe_hit2, mem_hit1, mem_hit2;
  logic  raw_stall, bubble;

  hazard_match u_exe_src1 (.slot(exe_q), .src(id_src1), .src_used(1'b1),       .hit(exe_hit1));
  hazard_match u_exe_src2 (.slot(exe_q), .src(id_src2), .src_used(id_two_src), .hit(exe_hit2));
  hazard_match u_mem_src1 (.slot(mem_q), .src(id_src1), .src_used(1'b1),       .hit(mem_hit1));
  hazard_match u_mem_src2 (.slot(mem_q), .src(id_src2), .src_used(id_two_src), .hit(mem_hit2));

  assign flush        = exe_branch_taken & ~mem_freeze;
  assign hazard_stall = raw_stall & ~flush;
  assign bubble       = hazard_stall | flush | ~id_valid;

  // WB slot retires tags; nothing downstream of the controller needs them.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= SLOT_BUBBLE;
      mem_q <= SLOT_BUBBLE;
      wb_q  <= SLOT_BUBBLE;
    end else if (!mem_freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      if (bubble) exe_q <= SLOT_BUBBLE;
      else        exe_q <= '{valid: 1'b1, dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};
    end
  end

`ifdef EXE_FWD_EN
  logic [1:0] sel1_q, sel2_q, sel1_d, sel2_d;

  // Only a load still in EXE cannot be bypassed; one bubble moves it to MEM/WB reach.
  assign raw_stall = id_valid & exe_q.valid & exe_q.mem_r_en & exe_q.wb_en
                   & (exe_hit1 | exe_hit2);

  // The EXE producer is in MEM when this instruction reaches EXE, so it wins over MEM.
  always_comb begin
    sel1_d = SEL_REG;
    sel2_d = SEL_REG;
    if (exe_hit1)      sel1_d = SEL_MEM;
    else if (mem_hit1) sel1_d = SEL_WB;
    if (exe_hit2)      sel2_d = SEL_MEM;
    else if (mem_hit2) sel2_d = SEL_WB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel1_q <= SEL_REG;
      sel2_q <= SEL_REG;
    end else if (!mem_freeze) begin
      sel1_q <= bubble ? SEL_REG : sel1_d;
      sel2_q <= bubble ? SEL_REG : sel2_d;
    end
  end

  assign sel_src1 = sel1_q;
  assign sel_src2 = sel2_q;
`else
  // No bypass network: wait until the producer has left MEM.
  assign raw_stall = id_valid & (exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2);
  assign sel_src1  = SEL_REG;
  assign sel_src2  = SEL_REG;
`endif

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Directed self-checking bench for exe_hazard_ctrl; expectations follow EXE_FWD_EN.
module tb_exe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src1, id_src2, id_dest;
  logic       id_two_src, id_wb_en, id_mem_r_en;
  logic       exe_branch_taken, mem_freeze;
  logic [1:0] sel_src1, sel_src2;
  logic       hazard_stall, flush;

  int tests = 0;
  int fails = 0;

  exe_hazard_ctrl #(.REG_W(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .exe_branch_taken(exe_branch_taken),
    .mem_freeze(mem_freeze), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .hazard_stall(hazard_stall), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb, input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dest = d; id_wb_en = wb; id_mem_r_en = ld;
    #1;
  endtask

  task automatic drain();
    exe_branch_taken = 1'b0; mem_freeze = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; exe_branch_taken = 1'b0; mem_freeze = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    set_id(1, 1, 2, 1, 3, 1, 1);
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL reset_sel1 got=%0d exp=0", sel_src1); end
    tests++; if (sel_src2 !== 2'd0) begin fails++; $display("FAIL reset_sel2 got=%0d exp=0", sel_src2); end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", hazard_stall); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got=%b exp=0", flush); end
  endtask

  // ADD r1 ; ADD r2,r1,r3
  task automatic test_dep_exe();
    drain();
    set_id(1, 4, 5, 1, 1, 1, 0); tick();
    set_id(1, 1, 3, 1, 2, 1, 0);
`ifdef EXE_FWD_EN
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL dep_exe_stall got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd1) begin fails++; $display("FAIL dep_exe_sel1 got=%0d exp=1", sel_src1); end
    tests++; if (sel_src2 !== 2'd0) begin fails++; $display("FAIL dep_exe_sel2 got=%0d exp=0", sel_src2); end
`else
    for (int i = 0; i < 2; i++) begin
      tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL dep_exe_stall%0d got=%b exp=1", i, hazard_stall); end
      tick();
    end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL dep_exe_release got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL dep_exe_sel1 got=%0d exp=0", sel_src1); end
    tests++; if (sel_src2 !== 2'd0) begin fails++; $display("FAIL dep_exe_sel2 got=%0d exp=0", sel_src2); end
`endif
  endtask

  // ADD r1 ; NOP ; SUB r4,r1,r1
  task automatic test_dep_mem();
    drain();
    set_id(1, 4, 5, 1, 1, 1, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0); tick();
    set_id(1, 1, 1, 1, 4, 1, 0);
`ifdef EXE_FWD_EN
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL dep_mem_stall got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd2) begin fails++; $display("FAIL dep_mem_sel1 got=%0d exp=2", sel_src1); end
    tests++; if (sel_src2 !== 2'd2) begin fails++; $display("FAIL dep_mem_sel2 got=%0d exp=2", sel_src2); end
`else
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL dep_mem_stall got=%b exp=1", hazard_stall); end
    tick();
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL dep_mem_release got=%b exp=0", hazard_stall); end
`endif
  endtask

  // LDR r5 ; ADD r6,r5,r0
  task automatic test_load_use();
    drain();
    set_id(1, 4, 0, 0, 5, 1, 1); tick();
    set_id(1, 5, 0, 1, 6, 1, 0);
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL load_use_stall got=%b exp=1", hazard_stall); end
    tick();
`ifdef EXE_FWD_EN
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL load_use_single got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd2) begin fails++; $display("FAIL load_use_sel1 got=%0d exp=2", sel_src1); end
    tests++; if (sel_src2 !== 2'd0) begin fails++; $display("FAIL load_use_sel2 got=%0d exp=0", sel_src2); end
`else
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL load_use_stall2 got=%b exp=1", hazard_stall); end
    tick();
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL load_use_release got=%b exp=0", hazard_stall); end
`endif
  endtask

  // src2 only counts when id_two_src; non-writing and invalid producers never match
  task automatic test_gating();
    drain();
    set_id(1, 4, 5, 1, 1, 1, 1); tick();
    set_id(1, 3, 1, 0, 2, 1, 0);
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL gate_two_src0 got=%b exp=0", hazard_stall); end
    set_id(1, 3, 1, 1, 2, 1, 0);
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL gate_two_src1 got=%b exp=1", hazard_stall); end
    set_id(0, 3, 1, 1, 2, 1, 0);
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL gate_id_invalid got=%b exp=0", hazard_stall); end
    drain();
    set_id(1, 4, 5, 1, 1, 0, 1); tick();
    set_id(1, 1, 1, 1, 2, 1, 0);
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL gate_no_wb got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL gate_no_wb_sel1 got=%0d exp=0", sel_src1); end
  endtask

  // Taken branch while a load-use sits in ID
  task automatic test_flush();
    drain();
    set_id(1, 4, 0, 0, 5, 1, 1); tick();
    set_id(1, 5, 0, 0, 7, 1, 0);
    exe_branch_taken = 1'b1; #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL flush_assert got=%b exp=1", flush); end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL flush_prio_stall got=%b exp=0", hazard_stall); end
    tick();
    exe_branch_taken = 1'b0;
    set_id(1, 7, 7, 1, 8, 1, 0);
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL flush_deassert got=%b exp=0", flush); end
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL flush_dropped got=%b exp=0", hazard_stall); end
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL flush_sel1 got=%0d exp=0", sel_src1); end
  endtask

  // Freeze for 3 cycles in the middle of ADD r1 ; ADD r2,r1,r3
  task automatic test_freeze();
    drain();
    set_id(1, 4, 5, 1, 1, 1, 0); tick();
    set_id(1, 1, 3, 1, 2, 1, 0);
    mem_freeze = 1'b1; exe_branch_taken = 1'b1; #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL freeze_gates_flush got=%b exp=0", flush); end
    exe_branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
`ifdef EXE_FWD_EN
      tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL freeze_hold_sel1_%0d got=%0d exp=0", i, sel_src1); end
      tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL freeze_hold_stall_%0d got=%b exp=0", i, hazard_stall); end
`else
      tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL freeze_hold_stall_%0d got=%b exp=1", i, hazard_stall); end
`endif
    end
    mem_freeze = 1'b0;
`ifdef EXE_FWD_EN
    tick(); set_id(0, 0, 0, 0, 0, 0, 0);
    tests++; if (sel_src1 !== 2'd1) begin fails++; $display("FAIL freeze_resume_sel1 got=%0d exp=1", sel_src1); end
    mem_freeze = 1'b1;
    repeat (2) tick();
    tests++; if (sel_src1 !== 2'd1) begin fails++; $display("FAIL freeze_sel1_held got=%0d exp=1", sel_src1); end
    mem_freeze = 1'b0;
    tick();
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL freeze_sel1_after got=%0d exp=0", sel_src1); end
`else
    tick();
    tests++; if (hazard_stall !== 1'b1) begin fails++; $display("FAIL freeze_resume_stall got=%b exp=1", hazard_stall); end
    tick();
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL freeze_resume_release got=%b exp=0", hazard_stall); end
`endif
  endtask

  // Reset wins over freeze
  task automatic test_reset_mid();
    drain();
    set_id(1, 4, 5, 1, 1, 1, 1); tick();
    set_id(1, 1, 3, 1, 2, 1, 0);
    tick();
    set_id(1, 2, 1, 1, 9, 1, 0);
    rst = 1'b1; mem_freeze = 1'b1;
    tick();
    rst = 1'b0; mem_freeze = 1'b0; #1;
    tests++; if (hazard_stall !== 1'b0) begin fails++; $display("FAIL rst_mid_stall got=%b exp=0", hazard_stall); end
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_mid_flush got=%b exp=0", flush); end
    tests++; if (sel_src1 !== 2'd0) begin fails++; $display("FAIL rst_mid_sel1 got=%0d exp=0", sel_src1); end
    tests++; if (sel_src2 !== 2'd0) begin fails++; $display("FAIL rst_mid_sel2 got=%0d exp=0", sel_src2); end
  endtask

  initial begin
    test_reset();
    test_dep_exe();
    test_dep_mem();
    test_load_use();
    test_gating();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
